// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Top-level sequencer for the stopwatch time-counter datapath.
//             Conditions the raw start/stop and lap buttons (2-FF sync,
//             debounce, rise detect). Runs the CLEAR/ZERO/RUN/LAP/PAUSE
//             state machine. Generates the gated count tick, counter clear
//             and display hold/load controls.
//  Ports    : CLK       - system clock, rising edge
//             reset     - synchronous active-high reset
//             strtstop  - raw start/stop button (async, active high)
//             lap       - raw lap/clear button (async, active high)
//             clken     - one-cycle count-enable pulse to the time counter
//             rst       - synchronous clear to the time counter
//             hold      - 1 = display register frozen
//             lap_load  - one-cycle pulse, display captures current count
//             running   - 1 while counting (RUN or LAP)
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic strtstop,
    input  logic lap,
    output logic clken,
    output logic rst,
    output logic hold,
    output logic lap_load,
    output logic running
);

    localparam int unsigned     c_PW      = $clog2(TICK_DIV);
    localparam int unsigned     c_DW      = $clog2(DEB_CYCLES + 1);
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_DW-1:0] c_DEB_MAX = c_DW'(DEB_CYCLES);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_ZERO  = 3'd1,
        S_RUN   = 3'd2,
        S_LAP   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = start/stop, index 1 = lap
    // ------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {lap, strtstop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            r_meta_q;
            logic            r_sync_q;
            logic            r_level_q;
            logic            r_level_prev_q;
            logic            r_press_q;
            logic [c_DW-1:0] r_cnt_q;

            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_meta_q       <= 1'b0;
                    r_sync_q       <= 1'b0;
                    r_level_q      <= 1'b0;
                    r_level_prev_q <= 1'b0;
                    r_press_q      <= 1'b0;
                    r_cnt_q        <= '0;
                end else begin
                    r_meta_q       <= w_btn_raw[gi];
                    r_sync_q       <= r_meta_q;
                    r_level_prev_q <= r_level_q;
                    r_press_q      <= r_level_q & ~r_level_prev_q;
                    // The counter tracks how many samples in a row have
                    // disagreed with the debounced level; the level only
                    // follows once the disagreement outlasts DEB_CYCLES
                    // samples, so shorter glitches are discarded.
                    if (r_sync_q == r_level_q) begin
                        r_cnt_q <= '0;
                    end else if (r_cnt_q == c_DEB_MAX) begin
                        r_cnt_q   <= '0;
                        r_level_q <= r_sync_q;
                    end else begin
                        r_cnt_q <= r_cnt_q + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press_q;
        end
    endgenerate

    logic w_start;
    logic w_lap;

    assign w_start = w_press[0];
    assign w_lap   = w_press[1];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t r_state_q;
    state_t w_state_d;
    logic   w_lap_load_d;

    always_comb begin
        w_state_d    = r_state_q;
        w_lap_load_d = 1'b0;
        case (r_state_q)
            S_CLEAR: w_state_d = S_ZERO;
            S_ZERO: begin
                if (w_start) w_state_d = S_RUN;
            end
            // Start always wins over a lap press in the same cycle.
            S_RUN: begin
                if (w_start) begin
                    w_state_d = S_PAUSE;
                end else if (w_lap) begin
                    w_state_d    = S_LAP;
                    w_lap_load_d = 1'b1;
                end
            end
            S_LAP: begin
                if (w_start) begin
                    w_state_d = S_PAUSE;
                end else if (w_lap) begin
                    w_lap_load_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_start) begin
                    w_state_d = S_RUN;
                end else if (w_lap) begin
                    w_state_d = S_CLEAR;
                end
            end
            default: w_state_d = S_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler: advances on the current state so that a wrap on the
    // edge leaving RUN/LAP still produces its tick; held in PAUSE to
    // keep the fractional tick across a pause/resume.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_pre_q;
    logic [c_PW-1:0] w_pre_d;
    logic            w_counting;
    logic            w_wrap;

    assign w_counting = (r_state_q == S_RUN) || (r_state_q == S_LAP);
    assign w_wrap     = w_counting && (r_pre_q == c_PRE_MAX);

    always_comb begin
        w_pre_d = r_pre_q;
        if (w_counting) begin
            w_pre_d = w_wrap ? '0 : r_pre_q + 1'b1;
        end else if (r_state_q != S_PAUSE) begin
            w_pre_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers; outputs decoded from next state so they move together
    // with the state register.
    // ------------------------------------------------------------------
    logic r_clken_q;
    logic r_rst_q;
    logic r_hold_q;
    logic r_lap_load_q;
    logic r_running_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state_q    <= S_CLEAR;
            r_pre_q      <= '0;
            r_clken_q    <= 1'b0;
            r_rst_q      <= 1'b1;
            r_hold_q     <= 1'b0;
            r_lap_load_q <= 1'b0;
            r_running_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_pre_q      <= w_pre_d;
            r_clken_q    <= w_wrap;
            r_rst_q      <= (w_state_d == S_CLEAR);
            r_hold_q     <= (w_state_d == S_LAP);
            r_lap_load_q <= w_lap_load_d;
            r_running_q  <= (w_state_d == S_RUN) || (w_state_d == S_LAP);
        end
    end

    assign clken    = r_clken_q;
    assign rst      = r_rst_q;
    assign hold     = r_hold_q;
    assign lap_load = r_lap_load_q;
    assign running  = r_running_q;

endmodule
`default_nettype wire
